// File: rtl/amp_stage_seq_pkg.sv
// Shared types and helpers for the amplifier-stage power-up/bias sequencer.
// State and fault-code encodings, timer sizing and the OUT window check.
package amp_stage_seq_pkg;

    typedef enum logic [3:0] {
        IDLE,
        RAIL_ON,
        BIAS_ON,
        SAMPLE,
        CHECK,
        RUN,
        FAIL,
        COOL,
        FAULT
    } state_e;

    typedef enum logic [1:0] {
        FC_NONE    = 2'd0,
        FC_LOW     = 2'd1,
        FC_HIGH    = 2'd2,
        FC_TIMEOUT = 2'd3
    } fault_code_e;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Unsigned compare of an ADC code against an inclusive [lo, hi] window.
    function automatic fault_code_e window_check(input logic [31:0] sample,
                                                 input logic [31:0] lo,
                                                 input logic [31:0] hi);
        if (sample < lo) return FC_LOW;
        if (sample > hi) return FC_HIGH;
        return FC_NONE;
    endfunction

endpackage

// File: rtl/amp_seq_timer.sv
// Loadable down-counter shared by every timed sequencer state.
// done_o pulses for one cycle on the last clock of a loaded interval.
module amp_seq_timer
    import amp_stage_seq_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] value_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q;

    // NOTE: sequential state is written with non-blocking <= so every register samples the same pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - W'(1);
        end
    end

    // A load of N therefore spans exactly N clocks before done is acted on.
    assign done_o = (cnt_q == W'(1));

endmodule

// File: rtl/amp_stage_sequencer.sv
// Power-up, bias and OUT-qualification sequencer for the common-emitter stage.
// Optional in-RUN re-sampling of OUT is built when AMP_STAGE_SEQ_MONITOR_EN is defined.
module amp_stage_sequencer
    import amp_stage_seq_pkg::*;
#(
    parameter int          SETTLE_CYCLES = 1000,
    parameter int          COOL_CYCLES   = 500,
    parameter int          ADC_TIMEOUT   = 64,
    parameter int          ADC_W         = 10,
    parameter int unsigned V_LO          = 300,
    parameter int unsigned V_HI          = 700,
    parameter int          MAX_RETRY     = 3
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                abort,
    output logic                                rail_en,
    output logic                                bias_en,
    output logic                                adc_req,
    input  logic                                adc_ack,
    input  logic [ADC_W-1:0]                    adc_data,
    output logic                                ready,
    output logic                                fault,
    output logic [1:0]                          fault_code,
    output logic [$clog2(MAX_RETRY+1)-1:0]      retry_cnt,
    output logic [ADC_W-1:0]                    last_sample
);

    localparam int TW = $clog2(max3(SETTLE_CYCLES, COOL_CYCLES, ADC_TIMEOUT)) + 1;
    localparam int RW = $clog2(MAX_RETRY + 1);

    state_e            state_q, state_d;
    logic              req_q, req_d;
    logic              rail_q, rail_d;
    logic              bias_q, bias_d;
    logic              ready_q, ready_d;
    logic              fault_q, fault_d;
    fault_code_e       fcode_q, fcode_d;
    fault_code_e       cand_q, cand_d;
    logic [RW-1:0]     retry_q, retry_d;
    logic [ADC_W-1:0]  sample_q, sample_d;

    logic              tmr_load;
    logic [TW-1:0]     tmr_val;
    logic              tmr_done;
    logic              ack_ok;
    fault_code_e       chk_code;

    amp_seq_timer #(.W(TW)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .load_i  (tmr_load),
        .value_i (tmr_val),
        .done_o  (tmr_done)
    );

    // Acks are only meaningful while a request is outstanding.
    assign ack_ok = adc_ack && req_q;

    // NOTE: every signal written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        fault_d  = fault_q;
        fcode_d  = fcode_q;
        cand_d   = cand_q;
        retry_d  = retry_q;
        sample_d = sample_q;
        tmr_load = 1'b0;
        tmr_val  = '0;
        chk_code = window_check(32'(sample_q), V_LO, V_HI);

        if (abort && state_q != IDLE) begin
            state_d = IDLE;
            req_d   = 1'b0;
            fault_d = 1'b0;
            fcode_d = FC_NONE;
            cand_d  = FC_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_d  = RAIL_ON;
                        fault_d  = 1'b0;
                        fcode_d  = FC_NONE;
                        cand_d   = FC_NONE;
                        retry_d  = '0;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(SETTLE_CYCLES);
                    end
                end
                RAIL_ON: begin
                    if (tmr_done) begin
                        state_d  = BIAS_ON;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(SETTLE_CYCLES);
                    end
                end
                BIAS_ON: begin
                    if (tmr_done) state_d = SAMPLE;
                end
                SAMPLE: begin
                    if (!req_q) begin
                        req_d    = 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(ADC_TIMEOUT);
                    end else if (ack_ok) begin
                        sample_d = adc_data;
                        req_d    = 1'b0;
                        state_d  = CHECK;
                    end else if (tmr_done) begin
                        req_d   = 1'b0;
                        cand_d  = FC_TIMEOUT;
                        state_d = FAIL;
                    end
                end
                CHECK: begin
                    if (chk_code == FC_NONE) begin
                        state_d  = RUN;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(SETTLE_CYCLES);
                    end else begin
                        cand_d  = chk_code;
                        state_d = FAIL;
                    end
                end
                RUN: begin
`ifdef AMP_STAGE_SEQ_MONITOR_EN
                    // Periodic re-qualification; the window check is done in place so ready never drops while healthy.
                    if (!req_q) begin
                        if (tmr_done) begin
                            req_d    = 1'b1;
                            tmr_load = 1'b1;
                            tmr_val  = TW'(ADC_TIMEOUT);
                        end
                    end else if (ack_ok) begin
                        sample_d = adc_data;
                        req_d    = 1'b0;
                        if (window_check(32'(adc_data), V_LO, V_HI) == FC_NONE) begin
                            tmr_load = 1'b1;
                            tmr_val  = TW'(SETTLE_CYCLES);
                        end else begin
                            cand_d  = window_check(32'(adc_data), V_LO, V_HI);
                            state_d = FAIL;
                        end
                    end else if (tmr_done) begin
                        req_d   = 1'b0;
                        cand_d  = FC_TIMEOUT;
                        state_d = FAIL;
                    end
`else
                    state_d = RUN;
`endif
                end
                FAIL: begin
                    if (retry_q < RW'(MAX_RETRY)) begin
                        retry_d  = retry_q + RW'(1);
                        state_d  = COOL;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(COOL_CYCLES);
                    end else begin
                        fault_d = 1'b1;
                        fcode_d = cand_q;
                        state_d = FAULT;
                    end
                end
                COOL: begin
                    if (tmr_done) begin
                        state_d  = RAIL_ON;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(SETTLE_CYCLES);
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            endcase
        end
    end

    // Enables are decoded from the next state so they register on the same edge as the transition.
    // FAIL keeps the stage powered; only COOL and FAULT provide the all-off interval.
    always_comb begin
        rail_d  = 1'b0;
        bias_d  = 1'b0;
        ready_d = 1'b0;
        case (state_d)
            RAIL_ON: rail_d = 1'b1;
            BIAS_ON, SAMPLE, CHECK, RUN, FAIL: begin
                rail_d = 1'b1;
                bias_d = 1'b1;
            end
            default: ;
        endcase
        ready_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            req_q    <= 1'b0;
            rail_q   <= 1'b0;
            bias_q   <= 1'b0;
            ready_q  <= 1'b0;
            fault_q  <= 1'b0;
            fcode_q  <= FC_NONE;
            cand_q   <= FC_NONE;
            retry_q  <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            rail_q   <= rail_d;
            bias_q   <= bias_d;
            ready_q  <= ready_d;
            fault_q  <= fault_d;
            fcode_q  <= fcode_d;
            cand_q   <= cand_d;
            retry_q  <= retry_d;
            sample_q <= sample_d;
        end
    end

    assign rail_en     = rail_q;
    assign bias_en     = bias_q;
    assign adc_req     = req_q;
    assign ready       = ready_q;
    assign fault       = fault_q;
    assign fault_code  = fcode_q;
    assign retry_cnt   = retry_q;
    assign last_sample = sample_q;

endmodule

// File: tb/tb_amp_stage_sequencer.sv
// Self-checking bench for amp_stage_sequencer: table-driven attempt vectors plus
// hand-written abort, reset and ignored-input sequences; captured samples go through a scoreboard.
module tb_amp_stage_sequencer;

    localparam int SETTLE    = 8;
    localparam int COOL      = 4;
    localparam int TMO       = 6;
    localparam int ADC_W     = 10;
    localparam int MAX_RETRY = 2;
    localparam int NVEC      = 9;
    localparam int BUDGET    = 200;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic             adc_ack = 1'b0;
    logic [ADC_W-1:0] adc_data = '0;
    logic             rail_en, bias_en, adc_req, ready, fault;
    logic [1:0]       fault_code;
    logic [1:0]       retry_cnt;
    logic [ADC_W-1:0] last_sample;

    amp_stage_sequencer #(
        .SETTLE_CYCLES (SETTLE),
        .COOL_CYCLES   (COOL),
        .ADC_TIMEOUT   (TMO),
        .ADC_W         (ADC_W),
        .V_LO          (300),
        .V_HI          (700),
        .MAX_RETRY     (MAX_RETRY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .abort       (abort),
        .rail_en     (rail_en),
        .bias_en     (bias_en),
        .adc_req     (adc_req),
        .adc_ack     (adc_ack),
        .adc_data    (adc_data),
        .ready       (ready),
        .fault       (fault),
        .fault_code  (fault_code),
        .retry_cnt   (retry_cnt),
        .last_sample (last_sample)
    );

    always #5 clk = ~clk;

    int               tests = 0;
    int               fails = 0;
    int               inv_err = 0;
    logic [ADC_W-1:0] sb_q[$];
    logic [ADC_W-1:0] model_last = '0;

    typedef struct {
        int                    n_att;
        logic [2:0][ADC_W-1:0] data;
        bit                    no_ack;
        bit                    exp_ready;
        bit                    exp_fault;
        int                    exp_code;
        int                    exp_retry;
    } vec_t;

    vec_t vecs[NVEC];

    always @(negedge clk) if (bias_en && !rail_en) inv_err++;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input int n, input int d0, input int d1, input int d2,
                                input bit na, input bit r, input bit f, input int c, input int rt);
        vec_t v;
        v.n_att     = n;
        v.data[0]   = ADC_W'(d0);
        v.data[1]   = ADC_W'(d1);
        v.data[2]   = ADC_W'(d2);
        v.no_ack    = na;
        v.exp_ready = r;
        v.exp_fault = f;
        v.exp_code  = c;
        v.exp_retry = rt;
        return v;
    endfunction

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // One power-up attempt: timing of rail/bias/req, then either an ack or a timed-out request.
    task automatic run_attempt(input logic [ADC_W-1:0] d, input bit no_ack, input bit first);
        int n;
        if (!first) begin
            n = 0;
            while (rail_en && n < BUDGET) begin n++; @(negedge clk); end
            n = 0;
            while (!rail_en && n < BUDGET) begin n++; @(negedge clk); end
            check("cool_gap", n, COOL);
        end else begin
            check("rail_up", int'(rail_en), 1);
        end
        n = 0;
        while (rail_en && !bias_en && n < BUDGET) begin n++; @(negedge clk); end
        check("rail_to_bias", n, SETTLE);
        n = 0;
        while (!adc_req && n < BUDGET) begin n++; @(negedge clk); end
        check("bias_to_req", n, SETTLE + 1);
        if (no_ack) begin
            n = 0;
            while (adc_req && n < BUDGET) begin n++; @(negedge clk); end
            check("req_width", n, TMO);
        end else begin
            repeat (3) @(negedge clk);
            adc_ack  = 1'b1;
            adc_data = d;
            sb_q.push_back(d);
            model_last = d;
            @(negedge clk);
            adc_ack = 1'b0;
            check("req_drop", int'(adc_req), 0);
            if (sb_q.size() == 0) check("sb_underflow", 1, 0);
            else check("last_sample", int'(last_sample), int'(sb_q.pop_front()));
        end
    endtask

    task automatic do_abort(input int exp_retry);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_outs", int'({rail_en, bias_en, adc_req, ready, fault, fault_code}), 0);
        check("abort_retry", int'(retry_cnt), exp_retry);
        check("abort_last", int'(last_sample), int'(model_last));
    endtask

    initial begin
        int n;
        vecs[0] = mk(1, 500, 0, 0,       0, 1, 0, 0, 0);
        vecs[1] = mk(3, 250, 250, 250,   0, 0, 1, 1, 2);
        vecs[2] = mk(2, 800, 450, 0,     0, 1, 0, 0, 1);
        vecs[3] = mk(3, 0, 0, 0,         1, 0, 1, 3, 2);
        vecs[4] = mk(1, 300, 0, 0,       0, 1, 0, 0, 0);
        vecs[5] = mk(1, 700, 0, 0,       0, 1, 0, 0, 0);
        vecs[6] = mk(3, 299, 701, 300,   0, 1, 0, 0, 2);
        vecs[7] = mk(3, 299, 299, 1023,  0, 0, 1, 2, 2);
        vecs[8] = mk(2, 0, 699, 0,       0, 1, 0, 0, 1);

        repeat (2) @(negedge clk);
        check("reset_outs", int'({rail_en, bias_en, adc_req, ready, fault, fault_code,
                                  retry_cnt, last_sample}), 0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < NVEC; i++) begin
            pulse_start();
            for (int a = 0; a < vecs[i].n_att; a++)
                run_attempt(vecs[i].data[a], vecs[i].no_ack, a == 0);
            n = 0;
            while (!ready && !fault && n < BUDGET) begin n++; @(negedge clk); end
            check($sformatf("v%0d_ready", i), int'(ready), int'(vecs[i].exp_ready));
            check($sformatf("v%0d_fault", i), int'(fault), int'(vecs[i].exp_fault));
            check($sformatf("v%0d_code", i), int'(fault_code), vecs[i].exp_code);
            check($sformatf("v%0d_retry", i), int'(retry_cnt), vecs[i].exp_retry);
            do_abort(vecs[i].exp_retry);
        end

        // start while running is ignored, and RUN never requests a sample in this build.
        pulse_start();
        run_attempt(ADC_W'(555), 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        check("run_ready", int'(ready), 1);
        pulse_start();
        n = 0;
        for (int c = 0; c < 20; c++) begin
            if (adc_req || !ready) n++;
            @(negedge clk);
        end
        check("run_stable", n, 0);
        do_abort(0);

        // start and abort together in IDLE: abort wins.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        check("start_abort_idle", int'({rail_en, bias_en}), 0);

        // Abort on the ack cycle: no capture, everything off; a stray ack later is ignored.
        pulse_start();
        n = 0;
        while (!adc_req && n < BUDGET) begin n++; @(negedge clk); end
        check("abort_ack_req_seen", int'(adc_req), 1);
        @(negedge clk);
        adc_ack  = 1'b1;
        adc_data = ADC_W'(600);
        abort    = 1'b1;
        @(negedge clk);
        adc_ack = 1'b0;
        abort   = 1'b0;
        check("abort_ack_outs", int'({rail_en, bias_en, adc_req, ready, fault, fault_code}), 0);
        check("abort_ack_last", int'(last_sample), int'(model_last));
        adc_ack  = 1'b1;
        adc_data = ADC_W'(123);
        @(negedge clk);
        adc_ack = 1'b0;
        @(negedge clk);
        check("stray_ack_last", int'(last_sample), int'(model_last));
        check("stray_ack_idle", int'({rail_en, adc_req}), 0);

        // Reset during BIAS_ON of a retry attempt, then a clean restart.
        pulse_start();
        run_attempt(ADC_W'(250), 1'b0, 1'b1);
        n = 0;
        while (rail_en && n < BUDGET) begin n++; @(negedge clk); end
        n = 0;
        while (!bias_en && n < BUDGET) begin n++; @(negedge clk); end
        check("pre_reset_bias", int'(bias_en), 1);
        check("pre_reset_retry", int'(retry_cnt), 1);
        rst_n = 1'b0;
        @(negedge clk);
        model_last = '0;
        check("mid_reset_outs", int'({rail_en, bias_en, adc_req, ready, fault, fault_code,
                                      retry_cnt, last_sample}), 0);
        rst_n = 1'b1;
        @(negedge clk);
        pulse_start();
        check("restart_rail", int'({rail_en, bias_en}), 2);
        check("restart_retry", int'(retry_cnt), 0);
        do_abort(0);

        check("bias_without_rail", inv_err, 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/amp_stage_sequencer.md
Name: amp_stage_sequencer

Overview:
Power-up and bias sequencer for the single-transistor common-emitter amplifier stage (Q1, R1–R5, the 5V and GND rails, and the IN and OUT nets).
- Power-up sequence: switch on the 5V rail, wait for it to settle, then enable input bias and wait again.
- Qualification: sample OUT through an external ADC over a req/ack handshake and check the sample against a voltage window.
- Result: report ready or a fault code; retry after a cool-down, up to a bounded number of attempts.
- Sits between system control and the analog-front-end enables/ADC port.

Parameters:
- SETTLE_CYCLES, 1000: wait after each enable step (rail, bias), in clocks; must be ≥1.
- COOL_CYCLES, 500: all-off wait before a retry, in clocks; must be ≥1.
- ADC_TIMEOUT, 64: maximum clocks adc_req stays high without adc_ack.
- ADC_W, 10: ADC sample width.
- V_LO, 300: minimum acceptable OUT code, inclusive.
- V_HI, 700: maximum acceptable OUT code, inclusive.
- MAX_RETRY, 3: retries allowed after the first failed attempt.

Ports:
- clk  in  1  Single clock.
- rst_n  in  1  Reset: synchronous, active-low.
- start  in  1  Single-cycle pulse; honoured only in IDLE.
- abort  in  1  Level; forces the shutdown path.
- rail_en  out  1  Enables the 5V rail.
- bias_en  out  1  Enables the IN bias drive.
- adc_req  out  1  ADC conversion request.
- adc_ack  in  1  ADC result valid; one-cycle pulse.
- adc_data  in  ADC_W  ADC result, sampled on adc_ack.
- ready  out  1  Stage qualified and running.
- fault  out  1  Sticky fault.
- fault_code  out  2  0 none, 1 below V_LO, 2 above V_HI, 3 ADC timeout.
- retry_cnt  out  $clog2(MAX_RETRY+1)  Retries consumed.
- last_sample  out  ADC_W  Most recent captured adc_data.

Behaviour:
- Reset (rst_n=0 at a clk edge): state IDLE; all outputs 0.
- All outputs are registered and decoded from state.
- IDLE: all enables off. start → RAIL_ON; clears fault, fault_code, retry_cnt.
- RAIL_ON: rail_en=1. Timer loads SETTLE_CYCLES; after exactly SETTLE_CYCLES clocks in-state → BIAS_ON.
- BIAS_ON: rail_en=1, bias_en=1. After SETTLE_CYCLES → SAMPLE.
- SAMPLE:
  - adc_req goes 1 on the cycle after entry and is held until adc_ack.
  - On the ack cycle: capture adc_data into last_sample, drop adc_req next cycle, → CHECK.
  - If ADC_TIMEOUT clocks pass without ack: fault_code candidate = 3, → FAIL.
- CHECK (one cycle):
  - V_LO ≤ sample ≤ V_HI → RUN.
  - sample < V_LO → code 1, FAIL.
  - sample > V_HI → code 2, FAIL.
  - Comparison is unsigned, full ADC_W width.
- RUN: rail_en=1, bias_en=1, ready=1. Holds until abort.
- FAIL (one cycle):
  - retry_cnt < MAX_RETRY → increment retry_cnt, → COOL.
  - Otherwise → FAULT; fault=1, fault_code latched.
- COOL: all enables off for COOL_CYCLES, then → RAIL_ON.
- FAULT: enables off; fault and fault_code held. Leaves only on abort or reset.
- abort=1 in any non-IDLE state:
  - → IDLE at the next edge; all enables, adc_req and ready drop that edge.
  - Clears fault; retry_cnt holds its value for readback.
  - abort has priority over every other transition, including ack/timeout on the same cycle.
- adc_ack when adc_req=0: ignored; last_sample unchanged.
- start outside IDLE: ignored.
- start and abort together in IDLE: abort wins; stay in IDLE.
- Reset mid-sequence: same as power-on reset; enables drop at that edge.
- bias_en is never 1 while rail_en is 0 (invariant).

Optional Feature:
- Macro: AMP_STAGE_SEQ_MONITOR_EN.
- Defined:
  - In RUN, re-sample OUT every SETTLE_CYCLES using the same handshake and window check; ready stays 1 during sampling.
  - Out-of-window result or ADC timeout → FAIL path with the matching code.
  - retry_cnt continues from its current value (not reset on entering RUN).
- Undefined: RUN never samples; adc_req stays 0 in RUN.

Decomposition:
- Package amp_stage_seq_pkg:
  - state enum: IDLE, RAIL_ON, BIAS_ON, SAMPLE, CHECK, RUN, FAIL, COOL, FAULT.
  - fault_code enum: FC_NONE, FC_LOW, FC_HIGH, FC_TIMEOUT.
- Sub-module amp_seq_timer: loadable down-counter, width $clog2 of the largest of SETTLE_CYCLES, COOL_CYCLES, ADC_TIMEOUT, plus 1; outputs a done pulse.
- The FSM instantiates one amp_seq_timer and shares it across states.

Test Plan:
Bench parameters: SETTLE=8, COOL=4, TIMEOUT=6, V_LO=300, V_HI=700, MAX_RETRY=2.
- start; ack with 500 four cycles after adc_req rises → rail_en 8 cycles before bias_en; ready=1; last_sample=500; fault=0.
- start; every attempt acks 250 → three attempts, each separated by 4 all-off cycles → FAULT, fault_code=1, retry_cnt=2.
- start; 800 on first attempt, then 450 → code 2 path with one COOL; RUN; retry_cnt=1; fault=0.
- start; adc_ack never arrives → adc_req high exactly 6 cycles per attempt; final fault_code=3.
- abort on the ack cycle in SAMPLE → next edge IDLE; all outputs 0; last_sample unchanged; stray ack afterwards ignored.
- rst_n=0 during BIAS_ON → rail_en and bias_en drop at that edge; start after release restarts at RAIL_ON with retry_cnt=0.
